// File: rtl/einsum_mult.sv
`default_nettype none
// ============================================================================
// Module   : einsum_mult
// Purpose  : Log-domain multiplier. It adds two log operands (24-bit, 4x6 or
//            2x12 packed) with NEG_INF propagation. The result is registered.
// Revision : 1.0 - initial release
// ============================================================================
module einsum_mult #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  bypass,
    input  logic [WORD_WIDTH-1:0] operand_a,
    input  logic [WORD_WIDTH-1:0] operand_b,
    input  logic [1:0]            pe_mode,
    output logic [WORD_WIDTH-1:0] product_out
);

    localparam logic [23:0] c_NEG_INF24 = 24'h800000;
    localparam logic [11:0] c_NEG_INF12 = 12'h800;
    localparam logic [5:0]  c_NEG_INF6  = 6'h20;

    localparam logic [1:0] c_MODE_4X6  = 2'b01;
    localparam logic [1:0] c_MODE_2X12 = 2'b10;

    logic [23:0]           w_a;
    logic [23:0]           w_b;
    logic [23:0]           w_sum_24;
    logic [23:0]           w_sum_4x6;
    logic [23:0]           w_sum_2x12;
    logic [23:0]           w_sum;
    logic [WORD_WIDTH-1:0] w_sum_ext;
    logic [WORD_WIDTH-1:0] r_product;

    assign w_a = operand_a[23:0];
    assign w_b = operand_b[23:0];

    always_comb begin
        w_sum_24 = w_a + w_b;
        if ((w_a == c_NEG_INF24) || (w_b == c_NEG_INF24)) begin
            w_sum_24 = c_NEG_INF24;
        end
    end

    // Each lane adds in its own width, so a carry cannot reach the next lane.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane6
            logic [5:0] w_la;
            logic [5:0] w_lb;
            assign w_la = w_a[6*i +: 6];
            assign w_lb = w_b[6*i +: 6];
            assign w_sum_4x6[6*i +: 6] =
                ((w_la == c_NEG_INF6) || (w_lb == c_NEG_INF6)) ? c_NEG_INF6 : (w_la + w_lb);
        end

        for (genvar j = 0; j < 2; j++) begin : g_lane12
            logic [11:0] w_la;
            logic [11:0] w_lb;
            assign w_la = w_a[12*j +: 12];
            assign w_lb = w_b[12*j +: 12];
            assign w_sum_2x12[12*j +: 12] =
                ((w_la == c_NEG_INF12) || (w_lb == c_NEG_INF12)) ? c_NEG_INF12 : (w_la + w_lb);
        end
    endgenerate

    // The reserved mode 11 falls through to the 24-bit path.
    always_comb begin
        case (pe_mode)
            c_MODE_4X6:  w_sum = w_sum_4x6;
            c_MODE_2X12: w_sum = w_sum_2x12;
            default:     w_sum = w_sum_24;
        endcase
    end

    always_comb begin
        w_sum_ext       = '0;
        w_sum_ext[23:0] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_product <= '0;
        end else if (enable) begin
            r_product <= bypass ? operand_a : w_sum_ext;
        end
    end

    assign product_out = r_product;

endmodule
`default_nettype wire

// File: tb/tb_einsum_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_einsum_mult
// Purpose  : Self-checking scoreboard bench for einsum_mult. It uses directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_einsum_mult;

    localparam int c_W = 32;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           bypass;
    logic [c_W-1:0] operand_a;
    logic [c_W-1:0] operand_b;
    logic [1:0]     pe_mode;
    logic [c_W-1:0] product_out;

    logic [c_W-1:0] r_exp_q[$];
    string          r_name_q[$];
    int             r_tests;
    int             r_fails;

    einsum_mult #(.WORD_WIDTH(c_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bypass      (bypass),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .pe_mode     (pe_mode),
        .product_out (product_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each queued entry is the value expected just after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (r_exp_q.size() > 0) begin
            logic [c_W-1:0] w_exp;
            string          w_nm;
            w_exp = r_exp_q.pop_front();
            w_nm  = r_name_q.pop_front();
            r_tests++;
            if (product_out !== w_exp) begin
                r_fails++;
                $display("FAIL %s: product_out=%08h required=%08h", w_nm, product_out, w_exp);
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic by, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input string nm);
        @(negedge clk);
        rst       = r;
        enable    = en;
        bypass    = by;
        pe_mode   = m;
        operand_a = a;
        operand_b = b;
        r_exp_q.push_back(exp);
        r_name_q.push_back(nm);
    endtask

    initial begin
        r_tests   = 0;
        r_fails   = 0;
        rst       = 1'b0;
        enable    = 1'b0;
        bypass    = 1'b0;
        pe_mode   = 2'b00;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);

        step(0, 1, 0, 2'b00, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h00000000, "reset");
        step(1, 0, 0, 2'b00, 32'h12345678, 32'h00000000, 32'h00000000, "hold_after_reset");

        step(1, 1, 0, 2'b00, 32'h00100000, 32'h00200000, 32'h00300000, "add24_a");
        step(1, 1, 0, 2'b00, 32'h00050000, 32'h00030000, 32'h00080000, "add24_b");
        step(1, 1, 0, 2'b00, 32'h00000000, 32'h00123456, 32'h00123456, "add24_zero");
        step(1, 1, 0, 2'b00, 32'h00100000, 32'h00020000, 32'h00120000, "b2b_0");
        step(1, 1, 0, 2'b00, 32'h00080000, 32'h00040000, 32'h000C0000, "b2b_1");
        step(1, 1, 0, 2'b00, 32'h00060000, 32'h00050000, 32'h000B0000, "b2b_2");
        step(1, 0, 1, 2'b00, 32'h11111111, 32'h22222222, 32'h000B0000, "hold_enable0");

        step(1, 1, 1, 2'b00, 32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE, "bypass_0");
        step(1, 1, 1, 2'b00, 32'hFEEDFACE, 32'hDEADBEEF, 32'hFEEDFACE, "bypass_1");
        step(1, 1, 1, 2'b01, 32'h12345678, 32'h00000000, 32'h12345678, "bypass_mode01");

        step(1, 1, 0, 2'b00, 32'h00800000, 32'h00123456, 32'h00800000, "neginf_a");
        step(1, 1, 0, 2'b00, 32'h00123456, 32'h00800000, 32'h00800000, "neginf_b");
        step(1, 1, 0, 2'b00, 32'h00800000, 32'h00800000, 32'h00800000, "neginf_ab");
        step(1, 1, 0, 2'b00, 32'h00FFFFFF, 32'h00000001, 32'h00000000, "wrap_ffffff");
        step(1, 1, 0, 2'b00, 32'h007FFFFF, 32'h00000001, 32'h00800000, "wrap_7fffff");
        step(1, 1, 0, 2'b00, 32'hFF100000, 32'hAB200000, 32'h00300000, "upper_bits_ignored");

        step(1, 1, 0, 2'b01, 32'h00010203, 32'h00040506, 32'h00050709, "m01_lanes");
        step(1, 1, 0, 2'b01, 32'h00111111, 32'h00111111, 32'h00222222, "m01_nocarry");
        step(1, 1, 0, 2'b01, 32'h00000000, 32'h00123456, 32'h00123456, "m01_zero");
        step(1, 1, 0, 2'b01, 32'h00000020, 32'h00000005, 32'h00000020, "m01_neginf");
        step(1, 1, 0, 2'b01, 32'h0000003F, 32'h00000001, 32'h00000000, "m01_lane_wrap");

        step(1, 1, 0, 2'b10, 32'h00800123, 32'h00001001, 32'h00800124, "m10_neginf_hi");
        step(1, 1, 0, 2'b10, 32'h00FFF001, 32'h00001FFF, 32'h00000000, "m10_lane_wrap");
        step(1, 1, 0, 2'b11, 32'h00100000, 32'h00200000, 32'h00300000, "m11_as_24");
        step(1, 1, 0, 2'b11, 32'h00000FFF, 32'h00000001, 32'h00001000, "m11_carry");

        step(0, 0, 1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "midstream_reset");

        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        for (int k = 0; k < 10 && r_exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (r_exp_q.size() > 0) begin
            r_fails++;
            $display("FAIL drain: pending=%0d required=0", r_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
